// File: rtl/l2_repl_ctrl_pkg.sv
// Shared L2 geometry and the replacement controller's state encoding.
// Every L2 replacement block takes its default sizes from here.
package l2_repl_ctrl_pkg;

  localparam int L2_NUM_SET   = 64;
  localparam int L2_SET_DEPTH = 6;
  localparam int L2_NUM_WAY   = 4;
  localparam int L2_WAY_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } repl_state_e;

endpackage

// File: rtl/fixed_pri_arb.sv
// Fixed-priority arbiter: grants the lowest-index request as a one-hot vector.
module fixed_pri_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Two's complement isolates the lowest set bit of req.
  assign gnt = req & (~req + N'(1));

endmodule

// File: rtl/lru_victim_pick.sv
// Combinational victim selection for one set: free unlocked way first,
// otherwise the least-recently-used unlocked way.
module lru_victim_pick #(
  parameter int NUM_WAY   = 4,
  parameter int WAY_DEPTH = 2
) (
  input  logic [NUM_WAY-1:0][NUM_WAY-1:0] lru_row,
  input  logic [NUM_WAY-1:0]              way_valid,
  input  logic [NUM_WAY-1:0]              way_lock,
  output logic [WAY_DEPTH-1:0]            way,
  output logic                            inv,
  output logic                            fail
);

  logic [NUM_WAY-1:0] cand;
  logic [NUM_WAY-1:0] inv_req;
  logic [NUM_WAY-1:0] lru_req;
  logic [NUM_WAY-1:0] inv_gnt;
  logic [NUM_WAY-1:0] lru_gnt;
  logic [NUM_WAY-1:0] sel_gnt;

  assign cand    = ~way_lock;
  assign inv_req = cand & ~way_valid;

  // A candidate is LRU among candidates when no other candidate is older than it.
  always_comb begin
    lru_req = '0;
    for (int r = 0; r < NUM_WAY; r++) begin
      lru_req[r] = cand[r] && ((lru_row[r] & cand) == '0);
    end
  end

  fixed_pri_arb #(.N(NUM_WAY)) u_inv_arb (.req(inv_req), .gnt(inv_gnt));
  fixed_pri_arb #(.N(NUM_WAY)) u_lru_arb (.req(lru_req), .gnt(lru_gnt));

  assign sel_gnt = (|inv_req) ? inv_gnt : lru_gnt;

  one2bin #(.N(NUM_WAY), .W(WAY_DEPTH)) u_enc (.onehot(sel_gnt), .bin(way));

  assign inv  = |inv_req;
  assign fail = ~|cand;

endmodule

// File: rtl/one2bin.sv
// One-hot to binary encoder; an all-zero input encodes to zero.
module one2bin #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] bin
);

  // NOTE: bin gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) bin = bin | W'(i);
    end
  end

endmodule

// File: rtl/l2_repl_ctrl.sv
// L2 replacement controller: per-set matrix LRU state, hit touches, and a
// three-state request/response pipeline that picks and then promotes victims.
module l2_repl_ctrl
  import l2_repl_ctrl_pkg::*;
#(
  parameter int NUM_SET   = L2_NUM_SET,
  parameter int SET_DEPTH = L2_SET_DEPTH,
  parameter int NUM_WAY   = L2_NUM_WAY,
  parameter int WAY_DEPTH = L2_WAY_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 touch_valid_i,
  input  logic [SET_DEPTH-1:0] touch_set_i,
  input  logic [WAY_DEPTH-1:0] touch_way_i,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic [SET_DEPTH-1:0] alloc_set_i,
  input  logic [NUM_WAY-1:0]   alloc_way_valid_i,
  input  logic [NUM_WAY-1:0]   alloc_way_lock_i,
  output logic                 victim_valid_o,
  input  logic                 victim_ready_i,
  output logic [SET_DEPTH-1:0] victim_set_o,
  output logic [WAY_DEPTH-1:0] victim_way_o,
  output logic                 victim_inv_o,
  output logic                 victim_fail_o
);

  typedef logic [NUM_WAY-1:0][NUM_WAY-1:0] lru_mat_t;

  lru_mat_t lru_q [NUM_SET];
  lru_mat_t lru_d [NUM_SET];

  repl_state_e          state_q;
  logic                 alloc_ready_q;
  logic [SET_DEPTH-1:0] req_set_q;
  logic [NUM_WAY-1:0]   req_valid_q;
  logic [NUM_WAY-1:0]   req_lock_q;
  logic                 victim_valid_q;
  logic [SET_DEPTH-1:0] victim_set_q;
  logic [WAY_DEPTH-1:0] victim_way_q;
  logic                 victim_inv_q;
  logic                 victim_fail_q;

  logic [WAY_DEPTH-1:0] pick_way;
  logic                 pick_inv;
  logic                 pick_fail;
  logic                 victim_fire;

  assign victim_fire = victim_valid_q && victim_ready_i;

  // Make way w the most recent: it is newer than all others, none is newer than it.
  function automatic lru_mat_t lru_touch(input lru_mat_t m, input logic [WAY_DEPTH-1:0] w);
    lru_mat_t r;
    r = m;
    for (int i = 0; i < NUM_WAY; i++) r[i][w] = 1'b0;
    r[w]    = '1;
    r[w][w] = 1'b0;
    return r;
  endfunction

  // The victim promotion is applied on top of the touch so a same-set pair ends victim-MRU.
  always_comb begin
    for (int s = 0; s < NUM_SET; s++) begin
      lru_d[s] = lru_q[s];
      if (touch_valid_i && (touch_set_i == SET_DEPTH'(s)))
        lru_d[s] = lru_touch(lru_d[s], touch_way_i);
      if (victim_fire && !victim_fail_q && (victim_set_q == SET_DEPTH'(s)))
        lru_d[s] = lru_touch(lru_d[s], victim_way_q);
    end
  end

  // NOTE: the matrices live in flops, not RAM, precisely so reset can clear every set.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SET; s++) begin
      if (rst) lru_q[s] <= '0;
      else     lru_q[s] <= lru_d[s];
    end
  end

  // Selection reads the captured set's matrix as it stood at the start of CALC.
  lru_victim_pick #(
    .NUM_WAY  (NUM_WAY),
    .WAY_DEPTH(WAY_DEPTH)
  ) u_pick (
    .lru_row  (lru_q[req_set_q]),
    .way_valid(req_valid_q),
    .way_lock (req_lock_q),
    .way      (pick_way),
    .inv      (pick_inv),
    .fail     (pick_fail)
  );

  // NOTE: all state here updates with <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      alloc_ready_q  <= 1'b1;
      req_set_q      <= '0;
      req_valid_q    <= '0;
      req_lock_q     <= '0;
      victim_valid_q <= 1'b0;
      victim_set_q   <= '0;
      victim_way_q   <= '0;
      victim_inv_q   <= 1'b0;
      victim_fail_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alloc_valid_i) begin
            req_set_q     <= alloc_set_i;
            req_valid_q   <= alloc_way_valid_i;
            req_lock_q    <= alloc_way_lock_i;
            alloc_ready_q <= 1'b0;
            state_q       <= ST_CALC;
          end
        end
        ST_CALC: begin
          victim_set_q   <= req_set_q;
          victim_way_q   <= pick_way;
          victim_inv_q   <= pick_inv;
          victim_fail_q  <= pick_fail;
          victim_valid_q <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (victim_ready_i) begin
            victim_valid_q <= 1'b0;
            alloc_ready_q  <= 1'b1;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          victim_valid_q <= 1'b0;
          alloc_ready_q  <= 1'b1;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign alloc_ready_o  = alloc_ready_q;
  assign victim_valid_o = victim_valid_q;
  assign victim_set_o   = victim_set_q;
  assign victim_way_o   = victim_way_q;
  assign victim_inv_o   = victim_inv_q;
  assign victim_fail_o  = victim_fail_q;

endmodule

// File: tb/tb_l2_repl_ctrl.sv
// Scoreboard bench for l2_repl_ctrl: a recency-list model predicts each victim,
// and a negedge monitor compares every response the DUT presents.
module tb_l2_repl_ctrl;

  localparam int NS = 64;
  localparam int SD = 6;
  localparam int NW = 4;
  localparam int WD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          touch_valid_i;
  logic [SD-1:0] touch_set_i;
  logic [WD-1:0] touch_way_i;
  logic          alloc_valid_i;
  logic          alloc_ready_o;
  logic [SD-1:0] alloc_set_i;
  logic [NW-1:0] alloc_way_valid_i;
  logic [NW-1:0] alloc_way_lock_i;
  logic          victim_valid_o;
  logic          victim_ready_i;
  logic [SD-1:0] victim_set_o;
  logic [WD-1:0] victim_way_o;
  logic          victim_inv_o;
  logic          victim_fail_o;

  always #5 clk = ~clk;

  l2_repl_ctrl #(.NUM_SET(NS), .SET_DEPTH(SD), .NUM_WAY(NW), .WAY_DEPTH(WD)) dut (
    .clk              (clk),
    .rst              (rst),
    .touch_valid_i    (touch_valid_i),
    .touch_set_i      (touch_set_i),
    .touch_way_i      (touch_way_i),
    .alloc_valid_i    (alloc_valid_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_set_i      (alloc_set_i),
    .alloc_way_valid_i(alloc_way_valid_i),
    .alloc_way_lock_i (alloc_way_lock_i),
    .victim_valid_o   (victim_valid_o),
    .victim_ready_i   (victim_ready_i),
    .victim_set_o     (victim_set_o),
    .victim_way_o     (victim_way_o),
    .victim_inv_o     (victim_inv_o),
    .victim_fail_o    (victim_fail_o)
  );

  typedef struct {
    int set;
    int way;
    bit inv;
    bit fail;
  } exp_t;

  exp_t exp_q[$];
  int   age [NS][NW];  // per set, ways ordered oldest first
  int   checks   = 0;
  int   failures = 0;

  bit   accept_flag = 0;
  bit   fire_flag   = 0;
  int   obs_way, obs_inv, obs_fail;
  int   touch_mode    = 0;
  int   touch_fix_set = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < NW; i++) age[s][i] = i;
  endfunction

  function automatic void model_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < NW; i++) if (age[s][i] == w) p = i;
    for (int i = p; i < NW - 1; i++) age[s][i] = age[s][i+1];
    age[s][NW-1] = w;
  endfunction

  function automatic exp_t model_pick(input int s, input logic [NW-1:0] v, input logic [NW-1:0] l);
    exp_t e;
    logic [NW-1:0] cand;
    cand   = ~l;
    e.set  = s;
    e.way  = 0;
    e.inv  = 0;
    e.fail = 0;
    if (cand == '0) begin
      e.fail = 1;
    end else if ((cand & ~v) != '0) begin
      e.inv = 1;
      for (int i = NW - 1; i >= 0; i--) if (cand[i] && !v[i]) e.way = i;
    end else begin
      for (int i = NW - 1; i >= 0; i--) if (cand[age[s][i]]) e.way = age[s][i];
    end
    return e;
  endfunction

  // Reference model: advances on each clock edge from the bench-driven inputs.
  initial begin
    bit            pending = 0;
    int            req_set = 0;
    logic [NW-1:0] req_v = '0, req_l = '0;
    exp_t          cur;
    cur = '{set: 0, way: 0, inv: 0, fail: 1};
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        exp_q.delete();
        pending = 0;
      end else begin
        if (pending) begin
          cur = model_pick(req_set, req_v, req_l);
          exp_q.push_back(cur);
          pending = 0;
        end
        if (accept_flag) begin
          req_set = int'(alloc_set_i);
          req_v   = alloc_way_valid_i;
          req_l   = alloc_way_lock_i;
          pending = 1;
        end
        if (touch_valid_i) model_touch(int'(touch_set_i), int'(touch_way_i));
        if (fire_flag && !cur.fail) model_touch(cur.set, cur.way);
      end
    end
  end

  // Monitor: pops an expectation on each new response and checks it stays put until fire.
  initial begin
    bit   held = 0;
    exp_t h;
    forever begin
      @(negedge clk);
      accept_flag = !rst && alloc_valid_i && alloc_ready_o;
      fire_flag   = !rst && victim_valid_o && victim_ready_i;
      if (rst) begin
        held = 0;
      end else if (victim_valid_o) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            timeout_fail("scoreboard_empty");
          end else begin
            h    = exp_q.pop_front();
            held = 1;
            obs_way  = int'(victim_way_o);
            obs_inv  = int'(victim_inv_o);
            obs_fail = int'(victim_fail_o);
            check("victim_set",  int'(victim_set_o),  h.set);
            check("victim_way",  int'(victim_way_o),  h.way);
            check("victim_inv",  int'(victim_inv_o),  int'(h.inv));
            check("victim_fail", int'(victim_fail_o), int'(h.fail));
          end
        end else begin
          check("hold_set",  int'(victim_set_o),  h.set);
          check("hold_way",  int'(victim_way_o),  h.way);
          check("hold_inv",  int'(victim_inv_o),  int'(h.inv));
          check("hold_fail", int'(victim_fail_o), int'(h.fail));
        end
        if (fire_flag) held = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (touch_mode)
      1: begin
        touch_valid_i = 1'($urandom_range(0, 1));
        touch_set_i   = SD'($urandom_range(0, 7));
        touch_way_i   = WD'($urandom_range(0, NW - 1));
      end
      2: begin
        touch_valid_i = 1'b1;
        touch_set_i   = SD'(touch_fix_set);
        touch_way_i   = WD'($urandom_range(0, NW - 1));
      end
      default: touch_valid_i = 1'b0;
    endcase
  endtask

  task automatic do_alloc(input int set, input logic [NW-1:0] v, input logic [NW-1:0] l,
                          input int hold, input bit lat, input bit ft, input int fway);
    int n;
    alloc_valid_i     = 1'b1;
    alloc_set_i       = SD'(set);
    alloc_way_valid_i = v;
    alloc_way_lock_i  = l;
    n = 0;
    while (!alloc_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("alloc_ready_wait");
    tick();
    alloc_valid_i = 1'b0;
    if (lat) begin
      check("latency_edge1_valid", int'(victim_valid_o), 0);
      tick();
      check("latency_edge2_valid", int'(victim_valid_o), 1);
    end
    n = 0;
    while (!victim_valid_o && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("victim_valid_wait");
    repeat (hold) tick();
    victim_ready_i = 1'b1;
    if (ft) begin
      touch_valid_i = 1'b1;
      touch_set_i   = SD'(set);
      touch_way_i   = WD'(fway);
    end
    tick();
    victim_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    touch_valid_i = 1'b0; touch_set_i = '0; touch_way_i = '0;
    alloc_valid_i = 1'b0; alloc_set_i = '0;
    alloc_way_valid_i = '0; alloc_way_lock_i = '0;
    victim_ready_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_alloc_ready", int'(alloc_ready_o), 1);
    check("reset_victim_valid", int'(victim_valid_o), 0);
    check("reset_victim_set", int'(victim_set_o), 0);
    check("reset_victim_way", int'(victim_way_o), 0);
    check("reset_victim_inv", int'(victim_inv_o), 0);
    check("reset_victim_fail", int'(victim_fail_o), 0);

    // First request after reset, with latency measured edge by edge.
    do_alloc(5, 4'b1111, 4'b0000, 0, 1, 0, 0);
    check("d_set5_way", obs_way, 0);

    // Touch set 3 in order 0..3, then two consecutive victims.
    for (int w = 0; w < NW; w++) begin
      touch_valid_i = 1'b1; touch_set_i = SD'(3); touch_way_i = WD'(w);
      tick();
    end
    do_alloc(3, 4'b1111, 4'b0000, 0, 0, 0, 0);
    check("d_set3_first_way", obs_way, 0);
    do_alloc(3, 4'b1111, 4'b0000, 0, 0, 0, 0);
    check("d_set3_second_way", obs_way, 1);

    // Invalid way preferred; locked invalid way falls back to LRU; all locked fails.
    do_alloc(7, 4'b1011, 4'b0000, 0, 0, 0, 0);
    check("d_set7_inv_way", obs_way, 2);
    check("d_set7_inv_flag", obs_inv, 1);
    do_alloc(7, 4'b1011, 4'b0100, 0, 0, 0, 0);
    check("d_set7_lru_way", obs_way, 0);
    check("d_set7_lru_inv", obs_inv, 0);
    do_alloc(7, 4'b1111, 4'b1111, 1, 0, 0, 0);
    check("d_set7_fail", obs_fail, 1);
    check("d_set7_fail_way", obs_way, 0);
    do_alloc(7, 4'b1111, 4'b0000, 0, 0, 0, 0);
    check("d_set7_after_fail_way", obs_way, 1);

    // Held response under touches, then same-cycle touch and fire on set 9.
    touch_mode = 2; touch_fix_set = 9;
    do_alloc(9, 4'b1111, 4'b0000, 5, 0, 0, 0);
    check("d_set9_hold_way", obs_way, 0);
    touch_mode = 0; touch_valid_i = 1'b0;
    do_alloc(9, 4'b1011, 4'b0000, 0, 0, 1, 1);
    check("d_set9_fill_way", obs_way, 2);
    do_alloc(9, 4'b1111, 4'b1001, 0, 0, 0, 0);
    check("d_set9_second_mru", obs_way, 1);
    do_alloc(9, 4'b1111, 4'b1000, 0, 0, 0, 0);
    check("d_set9_oldest", obs_way, 0);

    // Randomized traffic on a few colliding sets with background touches.
    touch_mode = 1;
    for (int k = 0; k < 150; k++) begin
      logic [NW-1:0] v, l;
      v = ($urandom_range(0, 1) == 1) ? 4'b1111 : NW'($urandom);
      l = ($urandom_range(0, 3) == 0) ? NW'($urandom) : 4'b0000;
      do_alloc(int'($urandom_range(0, 7)), v, l, int'($urandom_range(0, 3)), 0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)));
    end
    touch_mode = 0; touch_valid_i = 1'b0;

    // Reset while a response is pending.
    alloc_valid_i = 1'b1; alloc_set_i = SD'(7);
    alloc_way_valid_i = 4'b1111; alloc_way_lock_i = 4'b0000;
    n = 0;
    while (!alloc_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("rst_alloc_ready_wait");
    tick();
    alloc_valid_i = 1'b0;
    n = 0;
    while (!victim_valid_o && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("rst_victim_valid_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_victim_valid", int'(victim_valid_o), 0);
    check("midrst_alloc_ready", int'(alloc_ready_o), 1);
    check("midrst_victim_way", int'(victim_way_o), 0);
    check("midrst_victim_set", int'(victim_set_o), 0);
    do_alloc(7, 4'b1111, 4'b0000, 0, 1, 0, 0);
    check("midrst_set7_way", obs_way, 0);
    do_alloc(3, 4'b1111, 4'b0000, 0, 0, 0, 0);
    check("midrst_set3_way", obs_way, 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_repl_ctrl.md
L2_REPL_CTRL -- requirements
Module: l2_repl_ctrl

Interface
REQ-001 SHALL have parameters: NUM_SET, default 64, number of sets; SET_DEPTH, default 6, log2(NUM_SET); NUM_WAY, default 4, ways per set; WAY_DEPTH, default 2, log2(NUM_WAY).
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports are listed below, one per line.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 touch_valid_i  input  1  hit-update strobe, no handshake.
REQ-006 touch_set_i  input  SET_DEPTH  set index of the hit.
REQ-007 touch_way_i  input  WAY_DEPTH  way index of the hit.
REQ-008 alloc_valid_i  input  1  victim request valid.
REQ-009 alloc_ready_o  output  1  victim request accept.
REQ-010 alloc_set_i  input  SET_DEPTH  set index needing a victim.
REQ-011 alloc_way_valid_i  input  NUM_WAY  per-way tag-valid bits of that set.
REQ-012 alloc_way_lock_i  input  NUM_WAY  per-way lock (pending MSHR); locked ways never chosen.
REQ-013 victim_valid_o  output  1  victim result valid.
REQ-014 victim_ready_i  input  1  victim result accept.
REQ-015 victim_set_o  output  SET_DEPTH  echoed set index.
REQ-016 victim_way_o  output  WAY_DEPTH  chosen way.
REQ-017 victim_inv_o  output  1  chosen way was invalid (no writeback).
REQ-018 victim_fail_o  output  1  all ways locked, no victim; victim_way_o=0.

Function
REQ-019 SHALL hold, per set, an NUM_WAY x NUM_WAY LRU matrix in flops; row r all-zero means way r is older than every other way.
REQ-020 Updating way w of a set SHALL, at the clock edge, set row w to ones except bit w, and clear column w in all rows.
REQ-021 A touch_valid_i cycle SHALL apply the REQ-020 update to (touch_set_i, touch_way_i) at that edge.
REQ-022 FSM states SHALL be IDLE, CALC, RESP; alloc_ready_o=1 only in IDLE.
REQ-023 IDLE: on alloc_valid_i&alloc_ready_o, SHALL capture set, valid and lock masks, then go to CALC.
REQ-024 CALC: SHALL read the captured set's matrix as registered at the start of the cycle, register the result, and go to RESP.
REQ-025 Selection SHALL use cand = ~lock; if any cand&~valid, it SHALL pick the lowest-index such way with inv=1.
REQ-026 Otherwise it SHALL pick the lowest-index cand way r with (row r & cand)==0, with inv=0.
REQ-027 If cand==0, it SHALL assert fail=1 with way=0 and inv=0.
REQ-028 RESP: victim_valid_o=1 and all victim outputs SHALL hold stable until victim_ready_i; on the fire edge it SHALL go to IDLE.
REQ-029 On RESP fire with fail=0, SHALL apply the REQ-020 update to (victim_set_o, victim_way_o), so the filled way becomes MRU.
REQ-030 When a touch and a victim fire hit the same set in one cycle, SHALL apply the touch first and the victim update second; different sets both update.
REQ-031 A touch in the same cycle as CALC SHALL NOT affect that selection; touches after CALC SHALL NOT alter the held result.
REQ-032 Minimum request-to-result latency SHALL be 2 cycles (accept edge, then victim_valid_o 2 edges later); throughput is at most one request per 3 cycles.

Reset
REQ-033 With rst high at an edge, all matrices SHALL clear to zero and the FSM SHALL enter IDLE.
REQ-034 Reset outputs: alloc_ready_o=1, victim_valid_o=0, victim_set_o=0, victim_way_o=0, victim_inv_o=0, victim_fail_o=0.
REQ-035 Reset mid-operation SHALL drop any in-flight request silently, with no LRU update.

Structure
REQ-036 NUM_SET, NUM_WAY, SET_DEPTH and WAY_DEPTH SHALL come from the shared L2 define file.
REQ-037 The selection logic (REQ-025..027) SHALL be one combinational sub-module, lru_victim_pick; the lowest-index picks SHALL reuse fixed_pri_arb and one2bin.

Verification
REQ-038 After reset, alloc set 5, valid=1111, lock=0000 -> way 0, inv=0, fail=0, victim_valid_o on the 2nd edge after accept.
REQ-039 Touch set 3 ways 0,1,2,3 in order; alloc set 3 valid=1111 lock=0000 -> way 0; alloc again after fire -> way 1.
REQ-040 Set 7, valid=1011, lock=0000 -> way 2, inv=1; valid=1011, lock=0100 -> LRU among 0,1,3, inv=0.
REQ-041 lock=1111 -> fail=1, way=0, set 7 matrix unchanged (compare before and after).
REQ-042 Hold victim_ready_i low 5 cycles while touching that set -> outputs stable; same-cycle touch way 1 and victim fire way 2 on set 9 -> way 2 MRU, way 1 second.
REQ-043 Assert rst during RESP -> next cycle victim_valid_o=0, alloc_ready_o=1, all matrices zero.
